mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Parametrised multi-cycle MIPS control FSM, successor to the fixed 13-state unit.
//  Adds ISA coverage: addi, andi, ori, jal, and distinct beq/bne.
//  Adds a variable-latency memory handshake, a wait-timeout guard and a global hold.
//  Sits between the IR opcode field and the multi-cycle datapath muxes/enables.
// PARAMETERS
//  OPCODE_W  6   opcode width; decode compares the low 6 bits
//  ALUOP_W   3   ALU op bus width: 000 add, 001 sub, 010 funct, 011 slt, 100 and, 101 or
//  MAX_WAIT  15  cycles a memory state may wait for mem_ready before timeout; >=1
// PORTS
//  clk            in   1         clock
//  rst            in   1         asynchronous, active-high reset
//  opcode         in   OPCODE_W  IR[31:26]
//  mem_ready      in   1         memory completes the current read/write this cycle
//  hold           in   1         freeze FSM; force all enables low
//  pc_write       out  1         unconditional PC load
//  pc_write_cond  out  1         conditional PC load (datapath uses zero ^ branch_ne)
//  branch_ne      out  1         1=bne, 0=beq
//  iord           out  1         0=PC address, 1=ALUOut address
//  mem_read       out  1         memory read request
//  mem_write      out  1         memory write request
//  ir_write       out  1         IR load
//  mem_to_reg     out  2         00 ALUOut, 01 MDR, 10 PC (link)
//  pc_source      out  2         00 ALU, 01 ALUOut, 10 jump target
//  alu_op         out  ALUOP_W   see ALUOP_W
//  alu_src_a      out  1         0=PC, 1=A
//  alu_src_b      out  2         00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2; zero-ext imm when alu_op=and/or
//  reg_write      out  1         RF write enable
//  reg_dst        out  2         00 rt, 01 rd, 10 r31
//  lui_en         out  1         RF write data = {imm,16'h0}
//  err_timeout    out  1         sticky memory-timeout flag
//  trap           out  1         illegal opcode / timeout trap (0 without macro)
//  state_o        out  4         current state encoding
// BEHAVIOUR
//  States: FETCH0 DECODE1 MADDR2 MRD3 MWB4 MWR5 REXE6 RWB7 BR8 J9 JAL10 IEXE11 IWB12 LUI13 TRAP14.
//  Reset: state=FETCH, wait_cnt=0, err_timeout=0, trap=0; all enables forced 0 while rst=1.
//  FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add.
//    pc_write and ir_write assert only in the cycle mem_ready=1; next is DECODE.
//  DECODE: alu_src_b=11, alu_op=add (branch target). Opcode dispatch:
//    100011/101011 -> MADDR; 000000 -> REXE; 000010 -> J; 000011 -> JAL.
//    000100/000101 -> BR; 001000/001010/001100/001101 -> IEXE; 001111 -> LUI; other -> illegal.
//  MADDR: alu_src_a=1, alu_src_b=10, add; -> MRD (lw) or MWR (sw).
//  MRD: iord=1, mem_read=1; mem_ready -> MWB.  MWB: mem_to_reg=01, reg_dst=00, reg_write=1; -> FETCH.
//  MWR: iord=1, mem_write=1 held until mem_ready; -> FETCH.
//  REXE: alu_src_a=1, alu_src_b=00, alu_op=funct; -> RWB.  RWB: reg_dst=01, reg_write=1; -> FETCH.
//  BR: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01, branch_ne=opcode[0]; -> FETCH.
//  J: pc_write=1, pc_source=10; -> FETCH.
//  JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10; -> FETCH.
//    Link write uses the pre-update PC (already PC+4).
//  IEXE: alu_src_a=1, alu_src_b=10; alu_op add/slt/and/or for 001000/001010/001100/001101; -> IWB.
//  IWB: same ALU controls, reg_dst=00, mem_to_reg=00, reg_write=1; -> FETCH.
//  LUI: reg_write=1, reg_dst=00, lui_en=1; -> FETCH.  Unlisted outputs are 0 in every state.
//  Wait counter: increments each cycle in FETCH/MRD/MWR while mem_ready=0; clears on state exit.
//    Timeout: wait_cnt==MAX_WAIT and mem_ready=0 -> err_timeout<=1 (sticky); FSM -> FETCH.
//    No PC/IR/RF update occurs on timeout, so the fetch is retried.
//  mem_ready=1 on the same cycle wait_cnt==MAX_WAIT: the access completes; no timeout.
//  hold=1: state and wait_cnt frozen; pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write forced 0.
//    The hold cycle does not count toward MAX_WAIT; mem_ready is ignored while hold=1.
//  rst mid-instruction: immediate return to FETCH; sticky flags cleared.
// CONFIGURATION
//  MC_CTRL_TRAP_EN defined:
//    Illegal opcode in DECODE, or a memory timeout, -> TRAP.
//    TRAP: trap=1, all enables 0, held until rst.
//  MC_CTRL_TRAP_EN undefined:
//    Illegal opcode -> FETCH (executes as NOP); timeout -> FETCH; trap tied 0; TRAP unreachable.
// TESTING
//  lw, mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1 only in state 4 with mem_to_reg=01.
//  sw, mem_ready low 3 cycles in MWR -> mem_write held 4 cycles, then FETCH; no reg_write.
//  bne (000101) -> BR with pc_write_cond=1, branch_ne=1, alu_op=001.
//    beq (000100) -> same controls with branch_ne=0.
//  jal -> JAL: pc_write=1, reg_dst=10, mem_to_reg=10, reg_write=1; ori -> IEXE alu_op=101, then IWB.
//  MAX_WAIT=4, mem_ready=0 in FETCH -> err_timeout=1 after 5 cycles; no pc_write/ir_write.
//    Returns to FETCH (trap=1 and state 14 with MC_CTRL_TRAP_EN).
//  opcode 111111 -> FETCH without macro, TRAP with macro.
//    hold=1 for 3 cycles in REXE -> state_o stays 6, then RWB.
//    rst pulse in MRD -> state_o=0, flags 0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: opcode dispatch, datapath mux/enable decode, memory wait guard.
// Optional feature: define MC_CTRL_TRAP_EN to route illegal opcodes and memory timeouts to a TRAP state.
module mc_control_fsm #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                hold,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic [1:0]          mem_to_reg,
    output logic [1:0]          pc_source,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic                lui_en,
    output logic                err_timeout,
    output logic                trap,
    output logic [3:0]          state_o
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MADDR  = 4'd2;
    localparam logic [3:0] S_MRD    = 4'd3;
    localparam logic [3:0] S_MWB    = 4'd4;
    localparam logic [3:0] S_MWR    = 4'd5;
    localparam logic [3:0] S_REXE   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BR     = 4'd8;
    localparam logic [3:0] S_J      = 4'd9;
    localparam logic [3:0] S_JAL    = 4'd10;
    localparam logic [3:0] S_IEXE   = 4'd11;
    localparam logic [3:0] S_IWB    = 4'd12;
    localparam logic [3:0] S_LUI    = 4'd13;
    localparam logic [3:0] S_TRAP   = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b101);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

`ifdef MC_CTRL_TRAP_EN
    localparam logic [3:0] S_FAULT = S_TRAP;
`else
    localparam logic [3:0] S_FAULT = S_FETCH;
`endif

    logic [3:0]       state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [5:0]       op6;
    logic             mem_state;
    logic             timeout;
    logic [ALUOP_W-1:0] imm_alu_op;

    assign op6       = opcode[5:0];
    assign mem_state = (state == S_FETCH) || (state == S_MRD) || (state == S_MWR);
    // A completing access on the last allowed cycle wins over the timeout.
    assign timeout   = mem_state && !hold && !mem_ready && (wait_cnt == WAIT_LIM);
    assign state_o   = state;

    always_comb begin
        case (op6)
            OP_SLTI: imm_alu_op = ALU_SLT;
            OP_ANDI: imm_alu_op = ALU_AND;
            OP_ORI:  imm_alu_op = ALU_OR;
            default: imm_alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (!hold) begin
            case (state)
                S_FETCH:  state_nxt = mem_ready ? S_DECODE : (timeout ? S_FAULT : S_FETCH);
                S_DECODE: begin
                    case (op6)
                        OP_LW, OP_SW:                     state_nxt = S_MADDR;
                        OP_RTYPE:                         state_nxt = S_REXE;
                        OP_J:                             state_nxt = S_J;
                        OP_JAL:                           state_nxt = S_JAL;
                        OP_BEQ, OP_BNE:                   state_nxt = S_BR;
                        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_nxt = S_IEXE;
                        OP_LUI:                           state_nxt = S_LUI;
                        default:                          state_nxt = S_FAULT;
                    endcase
                end
                S_MADDR:  state_nxt = (op6 == OP_SW) ? S_MWR : S_MRD;
                S_MRD:    state_nxt = mem_ready ? S_MWB : (timeout ? S_FAULT : S_MRD);
                S_MWR:    state_nxt = mem_ready ? S_FETCH : (timeout ? S_FAULT : S_MWR);
                S_REXE:   state_nxt = S_RWB;
                S_IEXE:   state_nxt = S_IWB;
                S_TRAP:   state_nxt = S_FAULT;
                default:  state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else if (!hold) begin
            state <= state_nxt;
            // Stalled memory states count up; any exit (completion or timeout) clears.
            if (mem_state && !mem_ready && !timeout)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout)
                err_timeout <= 1'b1;
        end
    end

`ifdef MC_CTRL_TRAP_EN
    assign trap = (state == S_TRAP);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 2'b00;
        pc_source     = 2'b00;
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        lui_en        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MWB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
            end
            S_MWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_REXE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                reg_dst   = 2'b01;
                reg_write = 1'b1;
            end
            S_BR: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = op6[0];
            end
            S_J: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            // PC already holds PC+4 here, so the link value is the current PC.
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
            end
            S_IEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_alu_op;
            end
            S_IWB: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_alu_op;
                reg_write = 1'b1;
            end
            S_LUI: begin
                reg_write = 1'b1;
                lui_en    = 1'b1;
            end
            default: ;
        endcase

        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            branch_ne     = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 2'b00;
            pc_source     = 2'b00;
            alu_op        = ALU_ADD;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            reg_write     = 1'b0;
            reg_dst       = 2'b00;
            lui_en        = 1'b0;
        end else if (hold) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: driver queues hand-computed per-cycle controls, monitor compares at negedge.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready, hold;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
    logic [1:0] mem_to_reg, pc_source, alu_src_b, reg_dst;
    logic [2:0] alu_op;
    logic       alu_src_a, reg_write, lui_en, err_timeout, trap;
    logic [3:0] state_o;

    mc_control_fsm #(.OPCODE_W(6), .ALUOP_W(3), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .hold(hold),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .pc_source(pc_source), .alu_op(alu_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .reg_dst(reg_dst), .lui_en(lui_en), .err_timeout(err_timeout), .trap(trap),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic pw, pwc, bne, iord, mr, mw, irw;
        logic [1:0] m2r, psrc;
        logic [2:0] aop;
        logic asa;
        logic [1:0] asb;
        logic rw;
        logic [1:0] rdst;
        logic lui, tmo, trp;
    } exp_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, JJ = 6'b000010;
    localparam logic [5:0] JAL = 6'b000011, BEQ = 6'b000100, BNE = 6'b000101, ORI = 6'b001101;
    localparam logic [5:0] LUI = 6'b001111, ILL = 6'b111111;

    exp_t sb[$];
    int   total = 0, bad = 0, nstep = 0;
    logic tmo_exp = 1'b0, trp_exp = 1'b0;

    function automatic exp_t f_fetch(logic rdy);
        exp_t e = '0; e.st = 4'd0; e.mr = 1; e.asb = 2'b01; e.pw = rdy; e.irw = rdy; return e;
    endfunction
    function automatic exp_t f_dec();
        exp_t e = '0; e.st = 4'd1; e.asb = 2'b11; return e;
    endfunction
    function automatic exp_t f_maddr();
        exp_t e = '0; e.st = 4'd2; e.asa = 1; e.asb = 2'b10; return e;
    endfunction
    function automatic exp_t f_mrd();
        exp_t e = '0; e.st = 4'd3; e.iord = 1; e.mr = 1; return e;
    endfunction
    function automatic exp_t f_mwb();
        exp_t e = '0; e.st = 4'd4; e.m2r = 2'b01; e.rw = 1; return e;
    endfunction
    function automatic exp_t f_mwr();
        exp_t e = '0; e.st = 4'd5; e.iord = 1; e.mw = 1; return e;
    endfunction
    function automatic exp_t f_rexe();
        exp_t e = '0; e.st = 4'd6; e.asa = 1; e.aop = 3'b010; return e;
    endfunction
    function automatic exp_t f_rwb();
        exp_t e = '0; e.st = 4'd7; e.rdst = 2'b01; e.rw = 1; return e;
    endfunction
    function automatic exp_t f_br(logic ne);
        exp_t e = '0; e.st = 4'd8; e.asa = 1; e.aop = 3'b001; e.pwc = 1; e.psrc = 2'b01; e.bne = ne; return e;
    endfunction
    function automatic exp_t f_j();
        exp_t e = '0; e.st = 4'd9; e.pw = 1; e.psrc = 2'b10; return e;
    endfunction
    function automatic exp_t f_jal();
        exp_t e = '0; e.st = 4'd10; e.pw = 1; e.psrc = 2'b10; e.rw = 1; e.rdst = 2'b10; e.m2r = 2'b10; return e;
    endfunction
    function automatic exp_t f_iexe(logic [2:0] aop);
        exp_t e = '0; e.st = 4'd11; e.asa = 1; e.asb = 2'b10; e.aop = aop; return e;
    endfunction
    function automatic exp_t f_iwb(logic [2:0] aop);
        exp_t e = '0; e.st = 4'd12; e.asa = 1; e.asb = 2'b10; e.aop = aop; e.rw = 1; return e;
    endfunction
    function automatic exp_t f_lui();
        exp_t e = '0; e.st = 4'd13; e.rw = 1; e.lui = 1; return e;
    endfunction
    function automatic exp_t f_trap();
        exp_t e = '0; e.st = 4'd14; return e;
    endfunction

    // One clock of stimulus; the expected outputs for this cycle go to the scoreboard.
    task automatic step(input logic [5:0] op, input logic rdy, input logic hld, input exp_t e);
        opcode = op; mem_ready = rdy; hold = hld;
        if (hld) begin
            e.pw = 0; e.pwc = 0; e.irw = 0; e.rw = 0; e.mr = 0; e.mw = 0;
        end
        e.tmo = tmo_exp; e.trp = trp_exp;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        exp_t e = '0;
        rst = 1'b1; mem_ready = 1'b0; hold = 1'b0;
        tmo_exp = 1'b0; trp_exp = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    exp_t m_exp, m_act;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_exp = sb.pop_front();
            m_act = '{state_o, pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
                      mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
                      lui_en, err_timeout, trap};
            total++;
            nstep++;
            if (m_act !== m_exp) begin
                bad++;
                $display("FAIL cycle%0d: got st=%0d ctl=%h, want st=%0d ctl=%h",
                         nstep, m_act.st, m_act, m_exp.st, m_exp);
            end
        end
    end

    initial begin
        rst = 1'b1; opcode = '0; mem_ready = 1'b0; hold = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // lw with memory always ready
        step(LW, 1, 0, f_fetch(1)); step(LW, 1, 0, f_dec()); step(LW, 1, 0, f_maddr());
        step(LW, 1, 0, f_mrd());    step(LW, 1, 0, f_mwb());
        // sw with three stall cycles in MWR
        step(SW, 1, 0, f_fetch(1)); step(SW, 1, 0, f_dec()); step(SW, 1, 0, f_maddr());
        for (int i = 0; i < 3; i++) step(SW, 0, 0, f_mwr());
        step(SW, 1, 0, f_mwr());
        // branches, jal, ori, lui
        step(BNE, 1, 0, f_fetch(1)); step(BNE, 1, 0, f_dec()); step(BNE, 1, 0, f_br(1));
        step(BEQ, 1, 0, f_fetch(1)); step(BEQ, 1, 0, f_dec()); step(BEQ, 1, 0, f_br(0));
        step(JAL, 1, 0, f_fetch(1)); step(JAL, 1, 0, f_dec()); step(JAL, 1, 0, f_jal());
        step(ORI, 1, 0, f_fetch(1)); step(ORI, 1, 0, f_dec());
        step(ORI, 1, 0, f_iexe(3'b101)); step(ORI, 1, 0, f_iwb(3'b101));
        step(LUI, 1, 0, f_fetch(1)); step(LUI, 1, 0, f_dec()); step(LUI, 1, 0, f_lui());
        // R-type frozen in REXE for three hold cycles
        step(RT, 1, 0, f_fetch(1)); step(RT, 1, 0, f_dec());
        for (int i = 0; i < 3; i++) step(RT, 1, 1, f_rexe());
        step(RT, 1, 0, f_rexe()); step(RT, 1, 0, f_rwb());
        // hold masks a ready fetch; held cycles do not count, ready at wait_cnt==MAX_WAIT completes
        step(JJ, 1, 1, f_fetch(1));
        step(JJ, 0, 0, f_fetch(0)); step(JJ, 0, 0, f_fetch(0));
        step(JJ, 0, 1, f_fetch(0));
        step(JJ, 0, 0, f_fetch(0)); step(JJ, 0, 0, f_fetch(0));
        step(JJ, 1, 0, f_fetch(1)); step(JJ, 1, 0, f_dec()); step(JJ, 1, 0, f_j());
        // illegal opcode
        step(ILL, 1, 0, f_fetch(1)); step(ILL, 1, 0, f_dec());
`ifdef MC_CTRL_TRAP_EN
        trp_exp = 1'b1;
        step(ILL, 1, 0, f_trap()); step(ILL, 1, 0, f_trap());
`else
        step(ILL, 0, 0, f_fetch(0));
`endif
        do_reset();
        // fetch timeout with MAX_WAIT=4
        for (int i = 0; i < 5; i++) step(LW, 0, 0, f_fetch(0));
        tmo_exp = 1'b1;
`ifdef MC_CTRL_TRAP_EN
        trp_exp = 1'b1;
        step(LW, 1, 0, f_trap());
        do_reset();
`endif
        // retried fetch, then reset in the middle of MRD
        step(LW, 1, 0, f_fetch(1)); step(LW, 1, 0, f_dec()); step(LW, 1, 0, f_maddr());
        step(LW, 0, 0, f_mrd());
        do_reset();
        step(LW, 1, 0, f_fetch(1));

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
